// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic light controller: state and lamp encodings,
// default phase durations and the lamp decode used by the controller FSM.
package tlc_pkg;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;
    localparam logic [CNT_W-1:0] CNT_ONE = 8'd1;

    localparam int DEF_T_MAIN_G = 10;
    localparam int DEF_T_SIDE_G = 6;
    localparam int DEF_T_YEL    = 3;
    localparam int DEF_T_ALLR   = 1;
    localparam int DEF_T_WALK   = 5;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    typedef enum logic [2:0] {
        MAIN_G = 3'd0,
        MAIN_Y = 3'd1,
        ALLR_1 = 3'd2,
        SIDE_G = 3'd3,
        SIDE_Y = 3'd4,
        WALK   = 3'd5,
        ALLR_2 = 3'd6
    } tlc_state_e;

    typedef struct packed {
        logic [2:0] mainLamp;
        logic [2:0] sideLamp;
        logic       walkLamp;
    } tlc_lamps_t;

    // Every state other than the two green/yellow pairs shows red both ways.
    function automatic tlc_lamps_t decodeLamps(input tlc_state_e s);
        tlc_lamps_t l;
        l.mainLamp = LAMP_RED;
        l.sideLamp = LAMP_RED;
        l.walkLamp = 1'b0;
        case (s)
            MAIN_G:  l.mainLamp = LAMP_GRN;
            MAIN_Y:  l.mainLamp = LAMP_YEL;
            SIDE_G:  l.sideLamp = LAMP_GRN;
            SIDE_Y:  l.sideLamp = LAMP_YEL;
            WALK:    l.walkLamp = 1'b1;
            default: ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// Phase timer: counts ticks since the last clear, saturating at the maximum,
// and flags the tick on which a phase of the given length is complete.
module tlc_phase_timer
    import tlc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             tick,
    input  logic [CNT_W-1:0] length,
    output logic             done,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear beats tick so the count reads 0 on the first cycle of the new phase.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (tick && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done  = tick && (count_q == (length - CNT_ONE));
    assign count = count_q;

endmodule

// File: rtl/traffic_light_ctrl.sv
// Main/side road traffic light controller with pedestrian walk phase.
// Lamps are registered from the next state, so they always match the state register.
module traffic_light_ctrl
    import tlc_pkg::*;
#(
    parameter int T_MAIN_G = DEF_T_MAIN_G,
    parameter int T_SIDE_G = DEF_T_SIDE_G,
    parameter int T_YEL    = DEF_T_YEL,
    parameter int T_ALLR   = DEF_T_ALLR,
    parameter int T_WALK   = DEF_T_WALK
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       ped_req,
    input  logic       side_car,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk,
    output logic [2:0] phase
);

    localparam logic [CNT_W-1:0] LEN_MAIN_G = T_MAIN_G[CNT_W-1:0];
    localparam logic [CNT_W-1:0] LEN_SIDE_G = T_SIDE_G[CNT_W-1:0];
    localparam logic [CNT_W-1:0] LEN_YEL    = T_YEL[CNT_W-1:0];
    localparam logic [CNT_W-1:0] LEN_ALLR   = T_ALLR[CNT_W-1:0];
    localparam logic [CNT_W-1:0] LEN_WALK   = T_WALK[CNT_W-1:0];

    tlc_state_e       state_q;
    tlc_state_e       state_d;
    logic             pedPending_q;
    tlc_lamps_t       lamps_q;

    logic [CNT_W-1:0] phaseLen;
    logic [CNT_W-1:0] timerCount;
    logic             timerDone;
    logic             demand;
    logic             exitPhase;
    logic             enterWalk;
    tlc_state_e       successor;

    tlc_phase_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (exitPhase),
        .tick   (tick),
        .length (phaseLen),
        .done   (timerDone),
        .count  (timerCount)
    );

    // MAIN_G is the only open-ended phase: after its minimum it waits for demand.
    always_comb begin
        phaseLen  = LEN_MAIN_G;
        successor = ALLR_2;
        demand    = side_car || pedPending_q;
        exitPhase = timerDone;
        case (state_q)
            MAIN_G: begin
                phaseLen  = LEN_MAIN_G;
                successor = MAIN_Y;
                exitPhase = tick && (timerCount >= (LEN_MAIN_G - CNT_ONE)) && demand;
            end
            MAIN_Y: begin
                phaseLen  = LEN_YEL;
                successor = ALLR_1;
            end
            ALLR_1: begin
                phaseLen  = LEN_ALLR;
                successor = pedPending_q ? WALK : SIDE_G;
            end
            SIDE_G: begin
                phaseLen  = LEN_SIDE_G;
                successor = SIDE_Y;
            end
            SIDE_Y: begin
                phaseLen  = LEN_YEL;
                successor = ALLR_2;
            end
            WALK: begin
                phaseLen  = LEN_WALK;
                successor = ALLR_2;
            end
            ALLR_2: begin
                phaseLen  = LEN_ALLR;
                successor = MAIN_G;
            end
            default: begin
                phaseLen  = LEN_ALLR;
                successor = ALLR_2;
                exitPhase = 1'b1;
            end
        endcase
        state_d   = exitPhase ? successor : state_q;
        enterWalk = exitPhase && (state_q == ALLR_1) && pedPending_q;
    end

    // A request landing on the edge that enters WALK is served by that WALK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ALLR_2;
            pedPending_q <= 1'b0;
            lamps_q      <= decodeLamps(ALLR_2);
        end else begin
            state_q <= state_d;
            lamps_q <= decodeLamps(state_d);
            if (enterWalk) begin
                pedPending_q <= 1'b0;
            end else if (ped_req) begin
                pedPending_q <= 1'b1;
            end
        end
    end

    assign main_light = lamps_q.mainLamp;
    assign side_light = lamps_q.sideLamp;
    assign walk       = lamps_q.walkLamp;
    assign phase      = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl: directed scenarios plus random
// traffic, compared every cycle against a tick-counting reference model.
module tb_traffic_light_ctrl;
    import tlc_pkg::*;

    localparam int P_MAIN_G = 4;
    localparam int P_SIDE_G = 3;
    localparam int P_YEL    = 2;
    localparam int P_ALLR   = 1;
    localparam int P_WALK   = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       ped_req;
    logic       side_car;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk;
    logic [2:0] phase;

    int checkCount = 0;
    int passCount  = 0;
    int cycNum     = 0;

    tlc_state_e mPhase;
    int         mElapsed;
    bit         mPending;

    int         walkEntries;
    int         walkCycles;
    int         sideGEntries;
    logic       prevWalk;
    logic [2:0] prevPhase;

    traffic_light_ctrl #(
        .T_MAIN_G (P_MAIN_G),
        .T_SIDE_G (P_SIDE_G),
        .T_YEL    (P_YEL),
        .T_ALLR   (P_ALLR),
        .T_WALK   (P_WALK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .ped_req    (ped_req),
        .side_car   (side_car),
        .main_light (main_light),
        .side_light (side_light),
        .walk       (walk),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic int phaseLen(input tlc_state_e p);
        case (p)
            MAIN_G:         return P_MAIN_G;
            MAIN_Y, SIDE_Y: return P_YEL;
            SIDE_G:         return P_SIDE_G;
            WALK:           return P_WALK;
            default:        return P_ALLR;
        endcase
    endfunction

    // {main, side, walk} expected for each phase, written straight from the lamp table.
    function automatic logic [6:0] expLamps(input tlc_state_e p);
        case (p)
            MAIN_G:  return 7'b001_100_0;
            MAIN_Y:  return 7'b010_100_0;
            SIDE_G:  return 7'b100_001_0;
            SIDE_Y:  return 7'b100_010_0;
            WALK:    return 7'b100_100_1;
            default: return 7'b100_100_0;
        endcase
    endfunction

    task automatic modelReset();
        mPhase   = ALLR_2;
        mElapsed = 0;
        mPending = 1'b0;
    endtask

    // Model tracks ticks spent in the current phase; a phase is over once it has
    // seen its full length of ticks (MAIN_G additionally needs demand).
    task automatic modelStep(input logic t, input logic pr, input logic sc);
        bit leave;
        bit enteringWalk;
        leave        = 1'b0;
        enteringWalk = 1'b0;
        if (t) begin
            mElapsed++;
            leave = (mElapsed >= phaseLen(mPhase)) && ((mPhase != MAIN_G) || sc || mPending);
        end
        if (leave) begin
            case (mPhase)
                MAIN_G: mPhase = MAIN_Y;
                MAIN_Y: mPhase = ALLR_1;
                ALLR_1: begin
                    if (mPending) begin
                        mPhase       = WALK;
                        enteringWalk = 1'b1;
                    end else begin
                        mPhase = SIDE_G;
                    end
                end
                SIDE_G: mPhase = SIDE_Y;
                SIDE_Y: mPhase = ALLR_2;
                WALK:   mPhase = ALLR_2;
                default: mPhase = MAIN_G;
            endcase
            mElapsed = 0;
        end
        if (enteringWalk) begin
            mPending = 1'b0;
        end else if (pr) begin
            mPending = 1'b1;
        end
    endtask

    task automatic resetCounters();
        walkEntries  = 0;
        walkCycles   = 0;
        sideGEntries = 0;
        prevWalk     = walk;
        prevPhase    = phase;
    endtask

    // One clock: drive inputs, advance the model on the edge, check at the falling edge.
    task automatic applyStimulus(input logic t, input logic pr, input logic sc);
        tick     = t;
        ped_req  = pr;
        side_car = sc;
        @(posedge clk);
        cycNum++;
        if (!rst) begin
            modelStep(t, pr, sc);
        end
        @(negedge clk);
        checkOutput("phase", 32'(phase), 32'(mPhase));
        checkOutput("lamps", 32'({main_light, side_light, walk}), 32'(expLamps(mPhase)));
        checkOutput("exclusive", 32'((|main_light[1:0]) && (|side_light[1:0])), 32'd0);
        if (walk && !prevWalk) walkEntries++;
        if (walk) walkCycles++;
        if ((phase == SIDE_G) && (prevPhase != SIDE_G)) sideGEntries++;
        prevWalk  = walk;
        prevPhase = phase;
        tick      = 1'b0;
        ped_req   = 1'b0;
    endtask

    task automatic stepStd(input logic pr, input logic sc);
        applyStimulus((cycNum % 4) == 3, pr, sc);
    endtask

    task automatic runTicks(input int n, input logic sc);
        for (int i = 0; i < n * 4; i++) stepStd(1'b0, sc);
    endtask

    task automatic toTickCycle(input logic sc);
        while ((cycNum % 4) != 3) stepStd(1'b0, sc);
    endtask

    task automatic waitPhase(input tlc_state_e target, input logic sc, input int budget);
        int k;
        k = 0;
        while ((phase !== target) && (k < budget)) begin
            stepStd(1'b0, sc);
            k++;
        end
        checkOutput("reachPhase", 32'(phase), 32'(target));
    endtask

    // Reset is raised between clock edges so the output change proves it is asynchronous.
    task automatic applyReset();
        #2;
        rst     = 1'b1;
        tick    = 1'b0;
        ped_req = 1'b0;
        #1;
        checkOutput("rstPhase", 32'(phase), 32'(ALLR_2));
        checkOutput("rstLamps", 32'({main_light, side_light, walk}), 32'(7'b100_100_0));
        modelReset();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        logic sc;
        rst      = 1'b1;
        tick     = 1'b0;
        ped_req  = 1'b0;
        side_car = 1'b0;
        modelReset();

        // No demand: park in MAIN_G, then long enough for the counter to saturate.
        applyReset();
        resetCounters();
        runTicks(40, 1'b0);
        checkOutput("s1HoldMainG", 32'(phase), 32'(MAIN_G));
        checkOutput("s1Lamps", 32'({main_light, side_light}), 32'(6'b001_100));
        runTicks(230, 1'b0);
        runTicks(3, 1'b1);
        checkOutput("s1SatExit", 32'(phase), 32'(ALLR_1));

        // Side car held: full main/side rotation repeats.
        applyReset();
        resetCounters();
        runTicks(30, 1'b1);
        checkOutput("s2SideGEntries", 32'(sideGEntries), 32'd2);

        // Single pedestrian pulse on the first MAIN_G tick.
        applyReset();
        resetCounters();
        waitPhase(MAIN_G, 1'b0, 40);
        toTickCycle(1'b0);
        stepStd(1'b1, 1'b0);
        runTicks(40, 1'b0);
        checkOutput("s3WalkEntries", 32'(walkEntries), 32'd1);
        checkOutput("s3WalkCycles", 32'(walkCycles), 32'd12);
        checkOutput("s3EndMainG", 32'(phase), 32'(MAIN_G));

        // Request coinciding with the ALLR_1 -> WALK edge is absorbed.
        applyReset();
        resetCounters();
        waitPhase(MAIN_G, 1'b0, 40);
        stepStd(1'b1, 1'b0);
        waitPhase(ALLR_1, 1'b0, 80);
        toTickCycle(1'b0);
        stepStd(1'b1, 1'b0);
        checkOutput("s4EnterWalk", 32'(phase), 32'(WALK));
        runTicks(40, 1'b0);
        checkOutput("s4WalkEntries", 32'(walkEntries), 32'd1);

        // Request on WALK tick 2 earns a second WALK.
        applyReset();
        resetCounters();
        waitPhase(MAIN_G, 1'b0, 40);
        stepStd(1'b1, 1'b0);
        waitPhase(WALK, 1'b0, 80);
        toTickCycle(1'b0);
        stepStd(1'b0, 1'b0);
        toTickCycle(1'b0);
        stepStd(1'b1, 1'b0);
        runTicks(40, 1'b0);
        checkOutput("s5WalkEntries", 32'(walkEntries), 32'd2);
        checkOutput("s5EndMainG", 32'(phase), 32'(MAIN_G));

        // Reset in SIDE_G with a request pending discards the request.
        applyReset();
        resetCounters();
        waitPhase(SIDE_G, 1'b1, 100);
        stepStd(1'b1, 1'b1);
        stepStd(1'b0, 1'b1);
        applyReset();
        resetCounters();
        runTicks(40, 1'b0);
        checkOutput("s6WalkEntries", 32'(walkEntries), 32'd0);
        checkOutput("s6EndMainG", 32'(phase), 32'(MAIN_G));

        // Random traffic with irregular ticks and occasional resets.
        applyReset();
        resetCounters();
        sc = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 19) == 0) sc = ~sc;
            if ($urandom_range(0, 499) == 0) begin
                applyReset();
            end else begin
                applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, sc);
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl.md
TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 T_MAIN_G, 10, minimum main-road green phase length in ticks; range 1..255.
REQ-002 T_SIDE_G, 6, side-road green phase length in ticks; range 1..255.
REQ-003 T_YEL, 3, yellow phase length in ticks, both roads; range 1..255.
REQ-004 T_ALLR, 1, all-red clearance phase length in ticks; range 1..255.
REQ-005 T_WALK, 5, pedestrian walk phase length in ticks; range 1..255.
REQ-006 clk  input  1  single system clock; all state changes on its rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 tick  input  1  one-cycle timebase enable, nominally 1 Hz; phase timing counts only on tick=1 cycles.
REQ-009 ped_req  input  1  one-cycle pedestrian request pulse from the debounce_pulse block.
REQ-010 side_car  input  1  side-road vehicle sensor, level, synchronous to clk.
REQ-011 main_light  output  3  main-road lamps {R,Y,G}, one-hot.
REQ-012 side_light  output  3  side-road lamps {R,Y,G}, one-hot.
REQ-013 walk  output  1  pedestrian walk lamp.
REQ-014 phase  output  3  current state encoding, for debug and test.

Function
REQ-015 The FSM SHALL have seven states: MAIN_G, MAIN_Y, ALLR_1, SIDE_G, SIDE_Y, WALK, ALLR_2.
REQ-016 A phase counter SHALL clear to 0 on every state entry, increment on each tick while in the state, and saturate at 255.
REQ-017 A fixed-length state with length T SHALL exit in the cycle where tick=1 and count==T-1, i.e. on its T-th tick.
REQ-018 The fixed-length states SHALL be MAIN_Y (T_YEL), ALLR_1 and ALLR_2 (T_ALLR), SIDE_G (T_SIDE_G), SIDE_Y (T_YEL) and WALK (T_WALK).
REQ-019 MAIN_G SHALL exit to MAIN_Y only in a cycle with tick=1, count>=T_MAIN_G-1 and demand; demand is side_car=1 or ped_pending=1.
REQ-020 With no demand, MAIN_G SHALL hold indefinitely, with the counter saturating.
REQ-021 Transitions: MAIN_Y->ALLR_1; ALLR_1->WALK if ped_pending=1, else SIDE_G; SIDE_G->SIDE_Y; SIDE_Y->ALLR_2; WALK->ALLR_2; ALLR_2->MAIN_G.
REQ-022 ped_pending SHALL set on ped_req=1 and clear on the clock edge that enters WALK.
REQ-023 When a set and a clear of ped_pending coincide, the clear SHALL win and the request is considered served.
REQ-024 A ped_req arriving during WALK (after entry) SHALL set ped_pending and be served in a later cycle of the sequence.
REQ-025 Outputs SHALL be Moore, decoded only from the state register, with no combinational path from inputs.
REQ-026 Output decode: MAIN_G main=001 side=100; MAIN_Y main=010 side=100; SIDE_G main=100 side=001; SIDE_Y main=100 side=010; ALLR_1, ALLR_2 and WALK main=100 side=100.
REQ-027 walk SHALL be 1 only in WALK.
REQ-028 main_light and side_light SHALL never both have G or Y set in the same cycle.
REQ-029 ped_req or side_car changes in a cycle without tick SHALL affect only ped_pending, never the state or the counter.

Reset
REQ-030 On rst=1, state SHALL go to ALLR_2 immediately (asynchronously), with counter=0 and ped_pending=0.
REQ-031 During reset, outputs SHALL be main_light=100, side_light=100, walk=0, phase=ALLR_2 encoding.
REQ-032 Reset asserted mid-phase SHALL abandon the phase and discard any pending pedestrian request.
REQ-033 After reset release, the first transition SHALL be ALLR_2->MAIN_G on the T_ALLR-th tick.

Structure
REQ-034 Package tlc_pkg SHALL hold the state encodings, the lamp encodings (RED=100, YEL=010, GRN=001) and the default durations.
REQ-035 Sub-module tlc_phase_timer (clear, tick, length -> done, count) SHALL implement REQ-016 and REQ-017, and the FSM SHALL instantiate it once.

Verification (bench parameters: T_MAIN_G=4, T_SIDE_G=3, T_YEL=2, T_ALLR=1, T_WALK=3; tick every 4 clocks)
REQ-036 Reset release with no demand for 40 ticks -> ALLR_2 for 1 tick, then MAIN_G held for the remainder; main=001, side=100.
REQ-037 side_car=1 held from reset -> MAIN_G 4 ticks, MAIN_Y 2, ALLR_1 1, SIDE_G 3, SIDE_Y 2, ALLR_2 1, then repeats.
REQ-038 Single ped_req pulse on tick 1 of MAIN_G with side_car=0 -> MAIN_Y, ALLR_1, WALK with walk=1 for 3 ticks, ALLR_2, then MAIN_G with ped_pending=0.
REQ-039 ped_req coincident with the ALLR_1->WALK edge -> absorbed; no second WALK phase occurs.
REQ-040 ped_req during WALK tick 2 -> WALK completes, and after the next MAIN_G minimum a second WALK occurs.
REQ-041 rst pulsed during SIDE_G with ped_pending=1 -> outputs immediately 100/100; after release the sequence restarts from ALLR_2 with ped_pending=0; the REQ-028 assertion holds throughout.
